frame_autocorr: RTL and testbench

- Parametrised, frame-based autocorrelation engine for the LPC front end. Computes R[k] = sum x[n]*x[n-k] for k = 0..ORDER over one frame of FRAME_LEN samples.
- Delay-line history is cleared at each frame boundary, so R[k] uses only intra-frame products.
- Results are streamed out serially, lag 0 first, through a valid/ready port that feeds the Levinson-Durbin stage.
- Replaces the free-running fixed 10-lag correlator with frame framing, an input handshake, backpressure and a done pulse.

---
 rtl/lpc_pkg.sv | 11 +
 rtl/autocorr_lane.sv | 27 ++
 rtl/frame_autocorr.sv | 114 +++++++++++
 tb/tb_frame_autocorr.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// lpc_pkg: shared state encoding, default widths and lag-index sizing for the LPC front end
package lpc_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DRAIN} state_t;
    localparam int DATA_W = 16;
    localparam int ACC_W = 48;
    localparam int OUT_W = 16;
    localparam int OUT_SHIFT = 20;
    function automatic int lag_w(input int order);
        return $clog2(order + 1);
    endfunction
endpackage

// File: rtl/autocorr_lane.sv
// autocorr_lane: one lag's registered product x*d_k feeding a clearable signed accumulator
module autocorr_lane #(
    parameter int DATA_W = lpc_pkg::DATA_W,
    parameter int ACC_W = lpc_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);
    logic [2*DATA_W-1:0] prod, p;
    // low 2*DATA_W bits of the sign-extended product equal the signed product
    assign prod = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
    // product stage then accumulate stage; idle cycles feed a zero product
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            p <= '0;
            acc <= '0;
        end else begin
            p <= en ? prod : '0;
            acc <= acc + {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p};
        end
    end
endmodule

// File: rtl/frame_autocorr.sv
// frame_autocorr: per-frame autocorrelation R[0..ORDER], streamed out lag 0 first; FRAME_AUTOCORR_SAT_EN saturates output and adds r_sat
module frame_autocorr import lpc_pkg::*; #(
    parameter int DATA_W = lpc_pkg::DATA_W,
    parameter int ORDER = 10,
    parameter int FRAME_LEN = 160,
    parameter int ACC_W = lpc_pkg::ACC_W,
    parameter int OUT_SHIFT = lpc_pkg::OUT_SHIFT,
    parameter int OUT_W = lpc_pkg::OUT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      in_ready,
    output logic                      r_valid,
    input  logic                      r_ready,
    output logic [lag_w(ORDER)-1:0]   r_lag,
    output logic [OUT_W-1:0]          r_data,
`ifdef FRAME_AUTOCORR_SAT_EN
    output logic                      r_sat,
`endif
    output logic                      frame_done
);
    localparam int LW = lag_w(ORDER);
    localparam int CW = $clog2(FRAME_LEN);
    state_t state;
    logic [CW-1:0] cnt;
    logic fl, take, clr;
    logic [DATA_W-1:0] dl [ORDER];
    logic [DATA_W-1:0] tap [ORDER+1];
    logic [ACC_W-1:0] acc [ORDER+1];
    logic signed [ACC_W-1:0] sh;
    assign take = in_valid && in_ready;
    assign clr = state == IDLE || (r_valid && r_ready && r_lag == LW'(ORDER));
    // delay line d1..dORDER, restarted from zero every frame
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            dl <= '{default: '0};
        end else if (take) begin
            dl[0] <= in_data;
            for (int i = 1; i < ORDER; i++) dl[i] <= dl[i-1];
        end
    end
    for (genvar g = 0; g <= ORDER; g++) begin : g_lane
        if (g == 0) begin : g_zero
            assign tap[g] = in_data;
        end else begin : g_dly
            assign tap[g] = dl[g-1];
        end
        autocorr_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
            .clk(clk), .rst(rst), .clr(clr), .en(take),
            .a(in_data), .b(tap[g]), .acc(acc[g])
        );
    end
    // frame sequencing: accept samples, let the pipeline settle, then stream lags
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            in_ready <= 1'b0;
            r_valid <= 1'b0;
            r_lag <= '0;
            frame_done <= 1'b0;
            cnt <= '0;
            fl <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    state <= ACCUM;
                    in_ready <= 1'b1;
                    cnt <= '0;
                end
                ACCUM: if (take) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(FRAME_LEN - 1)) begin
                        state <= FLUSH;
                        in_ready <= 1'b0;
                        fl <= 1'b0;
                    end
                end
                FLUSH: begin
                    fl <= 1'b1;
                    if (fl) begin
                        state <= DRAIN;
                        r_valid <= 1'b1;
                        r_lag <= '0;
                    end
                end
                DRAIN: if (r_ready) begin
                    if (r_lag == LW'(ORDER)) begin
                        state <= ACCUM;
                        r_valid <= 1'b0;
                        in_ready <= 1'b1;
                        r_lag <= '0;
                        frame_done <= 1'b1;
                        cnt <= '0;
                    end else begin
                        r_lag <= r_lag + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign sh = $signed(acc[r_lag]) >>> OUT_SHIFT;
`ifdef FRAME_AUTOCORR_SAT_EN
    localparam logic signed [ACC_W-1:0] MX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MN = ~MX;
    assign r_data = sh > MX ? OUT_W'(MX) : sh < MN ? OUT_W'(MN) : OUT_W'(sh);
    assign r_sat = r_valid && (sh > MX || sh < MN);
`else
    assign r_data = OUT_W'(sh);
`endif
endmodule

// File: tb/tb_frame_autocorr.sv
// tb_frame_autocorr: randomized frames checked against a direct sum-of-products autocorrelation model
module tb_frame_autocorr;
    localparam int DW = 16;
    localparam int ORD = 10;
    localparam int FL = 160;
    localparam int OSH = 20;
    localparam int OW = 16;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic r_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic in_ready, r_valid, frame_done;
    logic [3:0] r_lag;
    logic [OW-1:0] r_data;
`ifdef FRAME_AUTOCORR_SAT_EN
    logic r_sat;
`endif
    int n_chk = 0;
    int n_fail = 0;
    int xs [FL];
    longint rr [ORD+1];

    always #5 clk = ~clk;

    frame_autocorr #(
        .DATA_W(DW), .ORDER(ORD), .FRAME_LEN(FL), .ACC_W(48), .OUT_SHIFT(OSH), .OUT_W(OW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .r_valid(r_valid), .r_ready(r_ready), .r_lag(r_lag), .r_data(r_data),
`ifdef FRAME_AUTOCORR_SAT_EN
        .r_sat(r_sat),
`endif
        .frame_done(frame_done)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] model(input longint r);
        longint s;
        s = r >>> OSH;
`ifdef FRAME_AUTOCORR_SAT_EN
        if (s > 32767) return {1'b1, 16'h7fff};
        if (s < -32768) return {1'b1, 16'h8000};
`endif
        return {1'b0, 16'(s)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < FL; i++) xs[i] = v;
    endtask

    task automatic fill_rand();
        logic signed [15:0] v;
        for (int i = 0; i < FL; i++) begin
            v = 16'($urandom);
            xs[i] = v;
        end
    endtask

    task automatic send(input int n, input int gaps);
        int i, g;
        logic t;
        i = 0;
        g = 0;
        while (i < n && g < 4000) begin
            in_valid = gaps == 0 ? 1'b1 : gaps == 1 ? ~in_valid : 1'($urandom % 2);
            in_data = DW'(xs[i]);
            t = in_valid && in_ready;
            tick();
            if (t) i++;
            g++;
        end
        in_valid = 1'b0;
        check("send_count", i, n);
    endtask

    task automatic run_frame(input int gaps, input int stall_lag, input bit rnd_ready);
        int n, w, nd;
        bit done;
        logic [16:0] e;
        for (int k = 0; k <= ORD; k++) begin
            rr[k] = 0;
            for (int j = k; j < FL; j++) rr[k] += longint'(xs[j]) * longint'(xs[j-k]);
        end
        send(FL, gaps);
        n = 1;
        while (!r_valid && n < 10) begin
            check("flush_in_ready", in_ready, 0);
            tick();
            n++;
        end
        check("latency", n, 3);
        nd = 0;
        for (int k = 0; k <= ORD; k++) begin
            e = model(rr[k]);
            if (k == stall_lag) begin
                repeat (5) begin
                    r_ready = 1'b0;
                    check("stall_lag", r_lag, k);
                    check("stall_data", r_data, e[15:0]);
                    check("stall_in_ready", in_ready, 0);
                    check("stall_done", frame_done, 0);
                    tick();
                end
            end
            w = 0;
            done = 1'b0;
            while (!done && w < 50) begin
                r_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
                check("r_valid", r_valid, 1);
                check("r_lag", r_lag, k);
                check("r_data", r_data, e[15:0]);
`ifdef FRAME_AUTOCORR_SAT_EN
                check("r_sat", r_sat, e[16]);
`endif
                done = r_ready && r_valid;
                tick();
                w++;
            end
            nd += w;
            check("frame_done", frame_done, k == ORD);
        end
        if (!rnd_ready && stall_lag < 0) check("drain_cycles", nd, ORD + 1);
        r_ready = 1'b0;
        check("post_valid", r_valid, 0);
        check("post_in_ready", in_ready, 1);
        tick();
        check("done_pulse", frame_done, 0);
    endtask

    task automatic check_reset();
        check("rst_in_ready", in_ready, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_r_lag", r_lag, 0);
        check("rst_r_data", r_data, 0);
        check("rst_frame_done", frame_done, 0);
    endtask

    initial begin
        tick();
        tick();
        check_reset();
        rst = 1'b1;
        fill_const(1024);
        run_frame(0, -1, 0);
        fill_const(0);
        xs[0] = 4096;
        run_frame(0, -1, 0);
        run_frame(0, -1, 0);
        fill_const(1024);
        run_frame(0, 3, 0);
        fill_rand();
        send(80, 0);
        rst = 1'b0;
        tick();
        check_reset();
        rst = 1'b1;
        fill_const(1024);
        run_frame(0, -1, 0);
        fill_const(32767);
        run_frame(0, -1, 0);
        fill_const(1024);
        run_frame(1, -1, 0);
        repeat (2) begin
            fill_rand();
            run_frame(2, -1, 1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
